// File: rtl/dotprod_feeder_pkg.sv
// Shared types and constants for the dot-product feeder and its issue tracker.
package dotprod_feeder_pkg;

    localparam int DATA_W       = 32;
    localparam int PIPE_LAT_DEF = 3;  // must match the multiply-add pipeline depth

    typedef enum logic [1:0] {
        IDLE,
        HALF,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/dotprod_feeder_issue_tracker.sv
// Tags each issue as it travels through the pipeline so only real partials are accumulated.
module feeder_issue_tracker #(
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    output logic add_en,
    output logic busy
);

    logic [PIPE_LAT:0] tag_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_sr <= '0;
        end else begin
            tag_sr <= {tag_sr[PIPE_LAT-1:0], issue};
        end
    end

    // The tap is high in the cycle the tagged partial sits on pc.
    assign add_en = tag_sr[PIPE_LAT];
    assign busy   = |tag_sr;

endmodule

// File: rtl/dotprod_feeder.sv
// Packs an element-pair stream two per issue onto a 2-lane multiply-add pipeline and accumulates the dot product.
module dotprod_feeder
    import dotprod_feeder_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic [DATA_W-1:0] pa1,
    output logic [DATA_W-1:0] pb1,
    output logic [DATA_W-1:0] pa2,
    output logic [DATA_W-1:0] pb2,
    input  logic [DATA_W-1:0] pc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [CNT_W-1:0]  res_count
);

    state_t            state;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              issue;
    logic              add_en;
    logic              busy;

    assign accept = in_valid & in_ready;
    assign issue  = accept & (in_last | (state == HALF));

    feeder_issue_tracker #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .issue  (issue),
        .add_en (add_en),
        .busy   (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
            acc       <= '0;
            cnt       <= '0;
            pa1       <= '0;
            pb1       <= '0;
            pa2       <= '0;
            pb2       <= '0;
            res_valid <= 1'b0;
        end else begin
            // Operands are only non-zero in the single cycle after an issue.
            pa1 <= '0;
            pb1 <= '0;
            pa2 <= '0;
            pb2 <= '0;
            if (add_en) begin
                acc <= acc + pc;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (in_last) begin
                            pa1      <= in_a;
                            pb1      <= in_b;
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            hold_a <= in_a;
                            hold_b <= in_b;
                            state  <= HALF;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                HALF: begin
                    if (accept) begin
                        cnt      <= cnt + 1'b1;
                        pa1      <= hold_a;
                        pb1      <= hold_b;
                        pa2      <= in_a;
                        pb2      <= in_b;
                        in_ready <= ~in_last;
                        state    <= in_last ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (!busy) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_data  = acc;
    assign res_count = cnt;

endmodule

// File: doc/dotprod_feeder.md
Name: dotprod_feeder

Overview:
- Drives the 2-lane multiply-add pipeline, which computes C = A1*B1 + A2*B2 mod 2^32 with fixed latency and no handshake.
- Accepts an arbitrary-length stream of element pairs (a,b) over valid/ready and packs them two per issue onto the pipeline's operand inputs.
- Accumulates the returned partial sums and presents the full 32-bit dot product on a valid/ready result port.
- Sits between the operand-sequencing logic and the pipeline; it is the issuing and collecting end of that interface.

Parameters:
- PIPE_LAT, 3, edges from the pipeline sampling its operands to C updating (step1, step2, C).
- CNT_W, 16, width of the element counter and res_count.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  element pair valid.
- in_ready  output  1  feeder can accept an element.
- in_a  input  32  element of vector A.
- in_b  input  32  element of vector B.
- in_last  input  1  final element of the current vector.
- pa1, pb1, pa2, pb2  output  32 each  registered operands to pipeline A1, B1, A2, B2.
- pc  input  32  pipeline result C.
- res_valid  output  1  result available.
- res_ready  input  1  result consumer ready.
- res_data  output  32  dot product mod 2^32.
- res_count  output  CNT_W  number of elements in the vector.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; in_ready=0 during reset.
  - pa1, pb1, pa2, pb2 = 0; res_valid=0; res_data=0; res_count=0.
  - Accumulator, lane-0 hold register, issue shift register and counters cleared.
  - Reset mid-operation discards all in-flight partials; no result is emitted.
- States and transitions:
  - IDLE: in_ready=1, no lane-0 element held.
    - Accepted element without last: store in lane-0 hold; go to HALF.
    - Accepted element with last: issue {a,b,0,0}; go to DRAIN.
  - HALF: in_ready=1, lane-0 element held.
    - Next accepted element: issue {hold_a, hold_b, a, b}.
    - If that element has in_last=1, go to DRAIN; otherwise return to IDLE.
  - DRAIN: in_ready=0. Wait until the issue shift register is empty and the last partial has been added; then go to DONE.
  - DONE: res_valid=1 with res_data and res_count stable. On res_valid & res_ready: clear accumulator and counters, go to IDLE.
  - Result consumer back-pressure holds DONE indefinitely.
- Issue timing:
  - An issue at edge k loads pa*/pb* for exactly one cycle; all operand registers are 0 in every non-issue cycle.
  - A 1 is shifted into a PIPE_LAT+1 deep issue shift register at edge k.
  - The partial for that issue is on pc after edge k+PIPE_LAT and is added to the accumulator at edge k+PIPE_LAT+1. pc is never added on untagged cycles.
  - Maximum issue rate is one every 2 accepted elements. Back-to-back issues are legal and must overlap in the pipeline.
- Arithmetic:
  - Accumulation is a 32-bit add, wrapping mod 2^32, with no overflow flag.
  - res_count increments per accepted element and wraps at 2^CNT_W.
- Boundaries:
  - A single-element vector pads lane 2 with zeros.
  - An odd-length vector pads lane 2 on the last issue.
  - in_valid held high in DRAIN or DONE is not accepted (in_ready=0).
  - The first element of the next vector is accepted no earlier than the cycle after the result handshake.
- End-to-end latency, from the last acceptance edge to res_valid rising: PIPE_LAT+2 edges.

Decomposition:
- Shared package:
  - state enum {IDLE, HALF, DRAIN, DONE};
  - DATA_W=32;
  - default PIPE_LAT=3, which must match the pipeline.
- One natural sub-module: feeder_issue_tracker. It holds the PIPE_LAT+1 shift register and exposes add_en (tap at output) and busy (any bit set).

Test Plan:
- A=[1,2,3], B=[4,5,6], last on the third element, res_ready=1:
  - two issues, {1,4,2,5} then {3,6,0,0};
  - res_data=32 (0x20), res_count=3;
  - res_valid for 1 cycle.
- Single element a=7, b=9 with last:
  - pa1=7, pb1=9, pa2=pb2=0 for 1 cycle;
  - res_data=63, res_count=1;
  - res_valid rises PIPE_LAT+2 edges after acceptance.
- Wrap: A=[0x10000, 1], B=[0x10000, 1] -> res_data=1.
- Back-pressure: res_ready=0 for 5 cycles after res_valid.
  - res_valid and res_data stay stable; in_ready=0 throughout.
  - The handshake on cycle 6 returns to IDLE with in_ready=1 the next cycle.
- Back-to-back: 4-element vector [1,1,1,1]·[2,2,2,2] fed with in_valid continuously high.
  - Issues on consecutive acceptance pairs; res_data=8.
  - The immediately following vector [3]·[3] yields 9 with no carry-over.
- Reset mid-DRAIN: drop rst_n two cycles after the last issue.
  - All outputs are 0 immediately and no res_valid occurs.
  - After release, vector [2]·[5] yields 10.
